// File: rtl/ram_loader_tx.sv
// ram_loader_tx: transmit side of the CPLD serial firmware-load protocol.
// Optional running byte checksum: define RAM_LOADER_TX_CHECKSUM_EN.
module ram_loader_tx #(
    parameter int AWIDTH      = 16,
    parameter int RAM_SIZE    = 16384,
    parameter int CLK_DIV     = 4,
    parameter int TRAILER_MAX = 8
) (
    input  logic              dsp_clk,
    input  logic              ram_loader_rst,
    input  logic              go,
    output logic [AWIDTH-1:0] src_addr,
    output logic              src_rd,
    input  logic [7:0]        src_data,
    input  logic              src_valid,
    output logic              cpld_clk,
    output logic              cpld_din,
    output logic              cpld_detached,
    input  logic              cpld_start,
    input  logic              cpld_mode,
    input  logic              cpld_done,
    output logic              busy,
    output logic              tx_done,
    output logic              tx_error,
    output logic [15:0]       checksum
);

    typedef enum logic [3:0] {
        S_IDLE, S_ARM, S_DETACH, S_FETCH, S_LOW,
        S_HIGH, S_TRAILER, S_DONE, S_ERROR
    } state_t;

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(RAM_SIZE - 1);
    localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0]        TMAX      = 8'(TRAILER_MAX);

    state_t            state, state_n;
    logic [1:0]        start_q, mode_q, done_q;
    logic              start_s, mode_s, done_s;
    logic [7:0]        cnt, cnt_n;
    logic [2:0]        bitcnt, bitcnt_n;
    logic [7:0]        shreg, shreg_n;
    logic [AWIDTH-1:0] addr_n;
    logic              clk_n, din_n, rd_n;
    logic [7:0]        tcnt, tcnt_n;
    logic              last;

`ifdef RAM_LOADER_TX_CHECKSUM_EN
    logic [15:0] csum, csum_n;
    assign checksum = csum;
`else
    assign checksum = 16'h0000;
`endif

    assign start_s = start_q[1];
    assign mode_s  = mode_q[1];
    assign done_s  = done_q[1];
    assign last    = (cnt == DIV_LAST);

    assign busy          = !(state inside {S_IDLE, S_DONE, S_ERROR});
    assign cpld_detached = state inside {S_IDLE, S_ARM, S_DONE, S_ERROR};
    assign tx_done       = (state == S_DONE);
    assign tx_error      = (state == S_ERROR);

    // Two-flop synchronisers for the asynchronous receiver flags.
    always_ff @(posedge dsp_clk or posedge ram_loader_rst) begin
        if (ram_loader_rst) begin
            start_q <= 2'b00;
            mode_q  <= 2'b00;
            done_q  <= 2'b00;
        end else begin
            start_q <= {start_q[0], cpld_start};
            mode_q  <= {mode_q[0], cpld_mode};
            done_q  <= {done_q[0], cpld_done};
        end
    end

    // State and datapath registers.
    always_ff @(posedge dsp_clk or posedge ram_loader_rst) begin
        if (ram_loader_rst) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            bitcnt   <= 3'd0;
            shreg    <= 8'd0;
            src_addr <= '0;
            cpld_clk <= 1'b0;
            cpld_din <= 1'b0;
            src_rd   <= 1'b0;
            tcnt     <= 8'd0;
`ifdef RAM_LOADER_TX_CHECKSUM_EN
            csum     <= 16'h0000;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bitcnt   <= bitcnt_n;
            shreg    <= shreg_n;
            src_addr <= addr_n;
            cpld_clk <= clk_n;
            cpld_din <= din_n;
            src_rd   <= rd_n;
            tcnt     <= tcnt_n;
`ifdef RAM_LOADER_TX_CHECKSUM_EN
            csum     <= csum_n;
`endif
        end
    end

    // Next-state, serial timing and byte sequencing.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 8'd1;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        addr_n   = src_addr;
        clk_n    = cpld_clk;
        din_n    = cpld_din;
        rd_n     = 1'b0;
        tcnt_n   = tcnt;
`ifdef RAM_LOADER_TX_CHECKSUM_EN
        csum_n   = csum;
`endif
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                clk_n = 1'b0;
                if (go) begin
                    state_n = S_ARM;
                    addr_n  = '0;
`ifdef RAM_LOADER_TX_CHECKSUM_EN
                    csum_n  = 16'h0000;
`endif
                end
            end
            S_ARM: begin
                if (start_s) begin
                    state_n = S_DETACH;
                    cnt_n   = 8'd0;
                end
            end
            S_DETACH: begin
                clk_n = 1'b0;
                if (!start_s) begin
                    state_n = S_ERROR;
                end else if (last) begin
                    state_n = S_FETCH;
                    rd_n    = 1'b1;
                    cnt_n   = 8'd0;
                end
            end
            S_FETCH: begin
                clk_n = 1'b0;
                if (!start_s) begin
                    state_n = S_ERROR;
                end else if (src_valid) begin
                    state_n  = S_LOW;
                    shreg_n  = src_data;
                    bitcnt_n = 3'd7;
                    din_n    = src_data[7];
                    cnt_n    = 8'd0;
`ifdef RAM_LOADER_TX_CHECKSUM_EN
                    csum_n   = csum + {8'h00, src_data};
`endif
                end
            end
            S_LOW: begin
                if (!start_s) begin
                    state_n = S_ERROR;
                    clk_n   = 1'b0;
                end else if (last) begin
                    state_n = S_HIGH;
                    clk_n   = 1'b1;
                    cnt_n   = 8'd0;
                end
            end
            S_HIGH: begin
                if (!start_s) begin
                    state_n = S_ERROR;
                    clk_n   = 1'b0;
                end else if (last) begin
                    clk_n = 1'b0;
                    cnt_n = 8'd0;
                    if (bitcnt != 3'd0) begin
                        state_n  = S_LOW;
                        shreg_n  = {shreg[6:0], 1'b0};
                        din_n    = shreg[6];
                        bitcnt_n = bitcnt - 3'd1;
                    end else if (src_addr != LAST_ADDR) begin
                        state_n = S_FETCH;
                        addr_n  = src_addr + 1'b1;
                        rd_n    = 1'b1;
                    end else begin
                        state_n = S_TRAILER;
                        din_n   = 1'b0;
                        tcnt_n  = 8'd0;
                    end
                end
            end
            S_TRAILER: begin
                din_n = 1'b0;
                if (last) begin
                    cnt_n = 8'd0;
                    clk_n = !cpld_clk;
                    if (!cpld_clk) begin
                        tcnt_n = tcnt + 8'd1;
                    end else if (mode_s && done_s && tcnt >= 8'd2) begin
                        state_n = S_DONE;
                    end else if (tcnt >= TMAX) begin
                        state_n = S_ERROR;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                clk_n   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_loader_tx.sv
// tb_ram_loader_tx: directed bench for ram_loader_tx with a byte scoreboard.
// Source and receiver are modelled in a sampling process off the falling edge.
module tb_ram_loader_tx;

    logic        dsp_clk = 1'b0;
    logic        ram_loader_rst;
    logic        go;
    logic [15:0] src_addr;
    logic        src_rd;
    logic [7:0]  src_data;
    logic        src_valid;
    logic        cpld_clk;
    logic        cpld_din;
    logic        cpld_detached;
    logic        cpld_start;
    logic        cpld_mode;
    logic        cpld_done;
    logic        busy;
    logic        tx_done;
    logic        tx_error;
    logic [15:0] checksum;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] rom [4];
    logic [7:0] exp_q [$];
    logic [7:0] dec_q [$];
    int         lat;
    logic       auto_rx;
    int         edges;
    int         viol;
    int         pend;
    int         req_addr;
    int         nb;
    logic [7:0] sh;
    logic       pclk;
    logic       pdin;
    logic [15:0] exp_ck;

    ram_loader_tx #(
        .AWIDTH(16), .RAM_SIZE(4), .CLK_DIV(4), .TRAILER_MAX(8)
    ) dut (
        .dsp_clk(dsp_clk),
        .ram_loader_rst(ram_loader_rst),
        .go(go),
        .src_addr(src_addr),
        .src_rd(src_rd),
        .src_data(src_data),
        .src_valid(src_valid),
        .cpld_clk(cpld_clk),
        .cpld_din(cpld_din),
        .cpld_detached(cpld_detached),
        .cpld_start(cpld_start),
        .cpld_mode(cpld_mode),
        .cpld_done(cpld_done),
        .busy(busy),
        .tx_done(tx_done),
        .tx_error(tx_error),
        .checksum(checksum)
    );

    always #5 dsp_clk = ~dsp_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_go();
        @(negedge dsp_clk);
        go = 1'b1;
        @(negedge dsp_clk);
        go = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge dsp_clk);
            if (tx_done || tx_error) break;
        end
        chk("end_reached", tx_done | tx_error, 1);
    endtask

    task automatic check_bytes(input string tag);
        chk({tag, "_nbytes"}, dec_q.size(), exp_q.size());
        while (dec_q.size() > 0 && exp_q.size() > 0) begin
            chk({tag, "_byte"}, dec_q.pop_front(), exp_q.pop_front());
        end
    endtask

    // Byte source, receiver and serial-line monitor.
    initial begin
        pend = 0; edges = 0; viol = 0; nb = 0; sh = 8'h00;
        pclk = 1'b0; pdin = 1'b0; req_addr = 0;
        src_valid = 1'b0; src_data = 8'h00;
        cpld_mode = 1'b0; cpld_done = 1'b0;
        forever begin
            @(negedge dsp_clk);
            #1;
            src_valid = 1'b0;
            if (ram_loader_rst) begin
                pend = 0;
            end else begin
                if (go) begin
                    edges = 0; nb = 0; viol = 0; pend = 0;
                    dec_q.delete();
                    exp_q.delete();
                    cpld_mode = 1'b0;
                    cpld_done = 1'b0;
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        src_valid = 1'b1;
                        src_data  = rom[req_addr];
                        exp_q.push_back(rom[req_addr]);
                    end
                end
                if (src_rd) begin
                    pend = lat;
                    req_addr = int'(src_addr[1:0]);
                end
            end
            if (cpld_clk && !pclk) begin
                edges++;
                if (edges <= 32) begin
                    sh = {sh[6:0], cpld_din};
                    nb++;
                    if (nb == 8) begin
                        dec_q.push_back(sh);
                        nb = 0;
                    end
                end
            end
            if (pclk && cpld_clk && cpld_din !== pdin) viol++;
            if (pend > 0 && cpld_clk) viol++;
            pclk = cpld_clk;
            pdin = cpld_din;
            if (auto_rx && edges >= 34) begin
                cpld_mode = 1'b1;
                cpld_done = 1'b1;
            end
        end
    end

    initial begin
        rom[0] = 8'hA5; rom[1] = 8'h3C; rom[2] = 8'h00; rom[3] = 8'hFF;
        exp_ck = 16'h0000;
`ifdef RAM_LOADER_TX_CHECKSUM_EN
        for (int i = 0; i < 4; i++) exp_ck = exp_ck + {8'h00, rom[i]};
`endif
        ram_loader_rst = 1'b1;
        go = 1'b0;
        cpld_start = 1'b0;
        lat = 1;
        auto_rx = 1'b1;
        repeat (3) @(negedge dsp_clk);

        chk("rst_clk", cpld_clk, 0);
        chk("rst_din", cpld_din, 0);
        chk("rst_detached", cpld_detached, 1);
        chk("rst_rd", src_rd, 0);
        chk("rst_addr", src_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_error", tx_error, 0);
        chk("rst_checksum", checksum, 0);
        @(negedge dsp_clk);
        ram_loader_rst = 1'b0;

        // Nominal image transfer.
        cpld_start = 1'b1;
        pulse_go();
        chk("t1_busy", busy, 1);
        wait_end(3000);
        chk("t1_done", tx_done, 1);
        chk("t1_edges", edges, 34);
        chk("t1_viol", viol, 0);
        chk("t1_checksum", checksum, exp_ck);
        chk("t1_detached", cpld_detached, 1);
        chk("t1_busy_end", busy, 0);
        check_bytes("t1");

        // Receiver not ready: hold in ARM.
        cpld_start = 1'b0;
        pulse_go();
        repeat (1000) @(negedge dsp_clk);
        chk("t2_detached", cpld_detached, 1);
        chk("t2_busy", busy, 1);
        chk("t2_edges", edges, 0);
        chk("t2_clk", cpld_clk, 0);
        cpld_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge dsp_clk);
            if (!cpld_detached) break;
        end
        chk("t2_detach_latency", cpld_detached, 0);
        wait_end(3000);
        chk("t2_done", tx_done, 1);
        check_bytes("t2");

        // Slow source: 20-cycle read latency.
        lat = 20;
        pulse_go();
        wait_end(5000);
        chk("t3_done", tx_done, 1);
        chk("t3_edges", edges, 34);
        chk("t3_viol", viol, 0);
        check_bytes("t3");

        // Receiver never enters SPI mode.
        lat = 1;
        auto_rx = 1'b0;
        pulse_go();
        wait_end(3000);
        chk("t4_error", tx_error, 1);
        chk("t4_edges", edges, 40);
        chk("t4_detached", cpld_detached, 1);
        chk("t4_clk", cpld_clk, 0);

        // Start dropped mid-byte, then restart.
        auto_rx = 1'b1;
        pulse_go();
        for (int i = 0; i < 1000; i++) begin
            @(negedge dsp_clk);
            if (edges >= 12) break;
        end
        chk("t5_reach_byte2", edges >= 12, 1);
        cpld_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge dsp_clk);
            if (tx_error) break;
        end
        chk("t5_error", tx_error, 1);
        chk("t5_clk", cpld_clk, 0);
        chk("t5_detached", cpld_detached, 1);
        cpld_start = 1'b1;
        pulse_go();
        chk("t5_addr_clear", src_addr, 0);
        chk("t5_ck_clear", checksum, 0);
        wait_end(3000);
        chk("t5_done", tx_done, 1);
        chk("t5_checksum", checksum, exp_ck);
        check_bytes("t5");

        // Reset while the serial clock is high.
        pulse_go();
        for (int i = 0; i < 300; i++) begin
            @(negedge dsp_clk);
            if (cpld_clk) break;
        end
        chk("t6_clk_high", cpld_clk, 1);
        ram_loader_rst = 1'b1;
        #1;
        chk("t6_clk", cpld_clk, 0);
        chk("t6_detached", cpld_detached, 1);
        chk("t6_busy", busy, 0);
        chk("t6_addr", src_addr, 0);
        @(negedge dsp_clk);
        ram_loader_rst = 1'b0;
        @(negedge dsp_clk);
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_done", tx_done, 0);
        chk("t6_idle_error", tx_error, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
